// File: rtl/mem_responder_pkg.sv
// Shared request/response payload types for the execute-stage memory channel.
package mem_responder_pkg;

    localparam int unsigned MEM_WORD_BYTES = 4;
    localparam int unsigned MEM_ADDR_W     = 32;
    localparam int unsigned MEM_DATA_W     = 8 * MEM_WORD_BYTES;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0]     addr;
        logic                      we;
        logic [MEM_WORD_BYTES-1:0] be;
        logic [MEM_DATA_W-1:0]     wdata;
    } mem_req_t;

    typedef struct packed {
        logic [MEM_DATA_W-1:0] rdata;
        logic                  err;
    } mem_resp_t;

endpackage

// File: rtl/mem_responder_resp_fifo.sv
// In-order response queue: push/pop with full/empty/count, pointers wrap modulo DEPTH.
module resp_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd];

    // A paired push/pop is always taken, so full or empty stays at the same count.
    assign w_do_push = i_push && (!o_full  || i_pop);
    assign w_do_pop  = i_pop  && (!o_empty || i_push);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= ptr_inc(r_wr);
            if (w_do_pop)  r_rd <= ptr_inc(r_rd);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr] <= i_push_data;
    end

endmodule

// File: rtl/mem_responder.sv
// Word-addressed data SRAM responder with fixed-latency pipe, in-order response FIFO and credits.
// Optional address fault checking is enabled by defining MEM_ACCESS_FAULT_EN.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_req_valid,
    output logic      o_req_ready,
    input  mem_req_t  i_req,
    output logic      o_resp_valid,
    input  logic      i_resp_ready,
    output mem_resp_t o_resp
);

    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned RESP_W = $bits(mem_resp_t);

    logic [MEM_DATA_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]      r_outstanding;
    logic [CNT_W-1:0]      w_outstanding_next;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_fault;
    logic                  w_req_fire;
    logic                  w_resp_fire;
    mem_resp_t             w_resp_new;
    logic                  w_push;
    logic [RESP_W-1:0]     w_push_data;
    logic [RESP_W-1:0]     w_fifo_head;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [CNT_W-1:0]      w_fifo_count;
    logic                  w_unused;

    assign w_idx = i_req.addr[2 +: IDX_W];

`ifdef MEM_ACCESS_FAULT_EN
    assign w_fault  = (i_req.addr[1:0] != 2'b00) ||
                      (i_req.addr >= MEM_ADDR_W'(MEM_WORD_BYTES * DEPTH));
    assign w_unused = ^{w_fifo_full, w_fifo_count};
`else
    assign w_fault  = 1'b0;
    assign w_unused = ^{w_fifo_full, w_fifo_count, i_req.addr[MEM_ADDR_W-1:2+IDX_W],
                        i_req.addr[1:0]};
`endif

    // Credits come from the registered count only; reset forces both handshakes off.
    assign o_req_ready  = !rst && (r_outstanding < CNT_W'(FIFO_DEPTH));
    assign o_resp_valid = !rst && !w_fifo_empty;
    assign o_resp       = mem_resp_t'(w_fifo_head);
    assign w_req_fire   = i_req_valid && o_req_ready;
    assign w_resp_fire  = o_resp_valid && i_resp_ready;

    always_comb begin
        w_outstanding_next = r_outstanding;
        case ({w_req_fire, w_resp_fire})
            2'b10:   w_outstanding_next = r_outstanding + CNT_W'(1);
            2'b01:   w_outstanding_next = r_outstanding - CNT_W'(1);
            default: w_outstanding_next = r_outstanding;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_outstanding <= '0;
        else     r_outstanding <= w_outstanding_next;
    end

    // Read returns the word as it was before this cycle's byte-enabled write.
    always_comb begin
        w_resp_new     = '0;
        w_resp_new.err = w_fault;
        if (!i_req.we && !w_fault) w_resp_new.rdata = r_mem[w_idx];
    end

    always_ff @(posedge clk) begin
        if (w_req_fire && i_req.we && !w_fault) begin
            for (int b = 0; b < MEM_WORD_BYTES; b++) begin
                if (i_req.be[b]) r_mem[w_idx][8*b +: 8] <= i_req.wdata[8*b +: 8];
            end
        end
    end

    generate
        if (LATENCY > 1) begin : g_pipe
            localparam int unsigned STAGES = LATENCY - 1;
            logic [STAGES-1:0] r_vld;
            mem_resp_t         r_data [STAGES];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld <= '0;
                end else begin
                    r_vld[0] <= w_req_fire;
                    for (int s = 1; s < STAGES; s++) r_vld[s] <= r_vld[s-1];
                end
            end

            always_ff @(posedge clk) begin
                r_data[0] <= w_resp_new;
                for (int s = 1; s < STAGES; s++) r_data[s] <= r_data[s-1];
            end

            assign w_push      = r_vld[STAGES-1];
            assign w_push_data = r_data[STAGES-1];
        end else begin : g_nopipe
            assign w_push      = w_req_fire;
            assign w_push_data = w_resp_new;
        end
    endgenerate

    resp_fifo #(
        .WIDTH (RESP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_resp_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_resp_fire),
        .o_head      (w_fifo_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed table, latency/credit/reset sequences, random scoreboard.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned FDEPTH = 4;
    localparam logic [31:0] TOP = 32'(4 * DEPTH);

    logic      clk = 1'b0;
    logic      rst;
    logic      req_valid;
    logic      req_ready;
    mem_req_t  req;
    logic      resp_valid;
    logic      resp_ready;
    mem_resp_t resp;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mm [16];
    mem_resp_t   exp_q [$];

    mem_responder #(.DEPTH(DEPTH), .LATENCY(2), .FIFO_DEPTH(FDEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req        (req),
        .o_resp_valid (resp_valid),
        .i_resp_ready (resp_ready),
        .o_resp       (resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic we, input logic [3:0] be,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] er, input logic ee);
        vec_t v;
        v.name = n; v.we = we; v.be = be; v.addr = a; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    // Reference: fault rule, word index, byte-masked write, rdata=0 for stores and faults.
    function automatic mem_resp_t model(input mem_req_t q);
        mem_resp_t r;
        int unsigned w;
        bit fault;
`ifdef MEM_ACCESS_FAULT_EN
        fault = (q.addr % 4 != 0) || (q.addr >= TOP);
`else
        fault = 1'b0;
`endif
        w = (q.addr / 4) % DEPTH;
        r.rdata = 32'h0;
        r.err   = fault;
        if (!fault) begin
            if (q.we) begin
                for (int b = 0; b < 4; b++)
                    if (q.be[b]) mm[w % 16][8*b +: 8] = q.wdata[8*b +: 8];
            end else begin
                r.rdata = mm[w % 16];
            end
        end
        return r;
    endfunction

    // One scoreboarded cycle: check credit, check any popped response, log any accepted request.
    task automatic sb_cycle(output bit accepted);
        mem_resp_t e;
        accepted = 1'b0;
        chk("req_ready_credit", 64'(req_ready), 64'(exp_q.size() < FDEPTH));
        if (resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 64'(resp_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("resp_rdata", 64'(resp.rdata), 64'(e.rdata));
                chk("resp_err", 64'(resp.err), 64'(e.err));
            end
        end
        if (req_valid && req_ready) begin
            exp_q.push_back(model(req));
            accepted = 1'b1;
        end
        tick();
    endtask

    task automatic do_req(input mem_req_t rq, output mem_resp_t rs, output bit got);
        int t;
        got = 1'b0;
        rs = '0;
        req = rq;
        req_valid = 1'b1;
        resp_ready = 1'b1;
        t = 0;
        while (!req_ready && t < 20) begin tick(); t++; end
        tick();
        req_valid = 1'b0;
        t = 0;
        while (!resp_valid && t < 20) begin tick(); t++; end
        if (resp_valid) begin
            rs = resp;
            got = 1'b1;
            tick();
        end
    endtask

    initial begin
        mem_req_t  rq;
        mem_resp_t rs;
        bit        got;
        bit        acc;
        int        cnt;
        int        t;
        mem_resp_t e;

        rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; req = '0;
        tick();
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(req_ready), 64'd1);

        // Directed table: byte enables, store responses, address wrap or fault.
        tbl[0] = mk("st_beef", 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        tbl[1] = mk("ld_beef", 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        tbl[2] = mk("st_aabb", 1'b1, 4'hF, 32'h20, 32'hAABBCCDD, 32'h0, 1'b0);
        tbl[3] = mk("st_be5", 1'b1, 4'h5, 32'h20, 32'h11223344, 32'h0, 1'b0);
        tbl[4] = mk("ld_be5", 1'b0, 4'hF, 32'h20, 32'h0, 32'hAA22CC44, 1'b0);
        tbl[5] = mk("st_be0", 1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b0);
        tbl[6] = mk("ld_be0", 1'b0, 4'hF, 32'h20, 32'h0, 32'hAA22CC44, 1'b0);
`ifdef MEM_ACCESS_FAULT_EN
        tbl[7]  = mk("ld_misal", 1'b0, 4'hF, 32'h13, 32'h0, 32'h0, 1'b1);
        tbl[8]  = mk("ld_top", 1'b0, 4'hF, TOP + 32'h10, 32'h0, 32'h0, 1'b1);
        tbl[9]  = mk("st_top", 1'b1, 4'hF, TOP + 32'h20, 32'h55555555, 32'h0, 1'b1);
        tbl[10] = mk("ld_after", 1'b0, 4'hF, 32'h20, 32'h0, 32'hAA22CC44, 1'b0);
`else
        tbl[7]  = mk("ld_misal", 1'b0, 4'hF, 32'h13, 32'h0, 32'hDEADBEEF, 1'b0);
        tbl[8]  = mk("ld_top", 1'b0, 4'hF, TOP + 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        tbl[9]  = mk("st_top", 1'b1, 4'hF, TOP + 32'h20, 32'h55555555, 32'h0, 1'b0);
        tbl[10] = mk("ld_after", 1'b0, 4'hF, 32'h20, 32'h0, 32'h55555555, 1'b0);
`endif
        for (int i = 0; i < 11; i++) begin
            rq.addr = tbl[i].addr; rq.we = tbl[i].we; rq.be = tbl[i].be; rq.wdata = tbl[i].wdata;
            do_req(rq, rs, got);
            chk({tbl[i].name, "_got"}, 64'(got), 64'd1);
            chk({tbl[i].name, "_rdata"}, 64'(rs.rdata), 64'(tbl[i].exp_rdata));
            chk({tbl[i].name, "_err"}, 64'(rs.err), 64'(tbl[i].exp_err));
        end

        // Latency: accept at cycle T with empty FIFO, valid first at T+2.
        tick();
        resp_ready = 1'b1;
        req = '{addr: 32'h10, we: 1'b0, be: 4'hF, wdata: 32'h0};
        req_valid = 1'b1;
        chk("lat_ready", 64'(req_ready), 64'd1);
        chk("lat_t0_valid", 64'(resp_valid), 64'd0);
        tick();
        req_valid = 1'b0;
        chk("lat_t1_valid", 64'(resp_valid), 64'd0);
        tick();
        chk("lat_t2_valid", 64'(resp_valid), 64'd1);
        chk("lat_t2_rdata", 64'(resp.rdata), 64'hDEADBEEF);
        tick();
        chk("lat_popped", 64'(resp_valid), 64'd0);

        // Prefill the 16 test words through the scoreboard.
        for (int i = 0; i < 16; i++) begin
            req = '{addr: 32'(i * 4), we: 1'b1, be: 4'hF, wdata: $urandom};
            req_valid = 1'b1;
            t = 0;
            do begin sb_cycle(acc); t++; end while (!acc && t < 20);
            req_valid = 1'b0;
        end

        // Random traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            req.addr = 32'($urandom_range(0, 15) * 4);
            case ($urandom % 8)
                0: req.addr = req.addr | 32'($urandom_range(1, 3));
                1: req.addr = req.addr + TOP * 32'($urandom_range(1, 3));
                default: ;
            endcase
            req.we = 1'($urandom % 2);
            req.be = 4'($urandom);
            req.wdata = $urandom;
            req_valid = ($urandom % 10) < 7;
            resp_ready = ($urandom % 10) < 6;
            sb_cycle(acc);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin sb_cycle(acc); t++; end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        // Credit exhaustion with resp.ready held low.
        resp_ready = 1'b0;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            req = '{addr: 32'(cnt * 4), we: 1'b0, be: 4'hF, wdata: 32'h0};
            req_valid = 1'b1;
            if (req_ready) begin
                exp_q.push_back(model(req));
                cnt++;
            end
            tick();
        end
        req_valid = 1'b0;
        chk("credit_accepted", 64'(cnt), 64'd4);
        chk("credit_ready_low", 64'(req_ready), 64'd0);
        resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("credit_resp_valid", 64'(resp_valid), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("credit_resp_rdata", 64'(resp.rdata), 64'(e.rdata));
            end
            if (k == 0) chk("credit_no_same_cycle", 64'(req_ready), 64'd0);
            tick();
            if (k == 0) chk("credit_after_pop", 64'(req_ready), 64'd1);
        end
        chk("credit_drained", 64'(resp_valid), 64'd0);

        // Reset with three requests outstanding drops them.
        resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req = '{addr: 32'(k * 4), we: 1'b0, be: 4'hF, wdata: 32'h0};
            req_valid = 1'b1;
            tick();
        end
        req_valid = 1'b0;
        tick();
        chk("pre_rst_valid", 64'(resp_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("in_rst_ready", 64'(req_ready), 64'd0);
        tick();
        chk("rst_next_valid", 64'(resp_valid), 64'd0);
        chk("rst_next_ready", 64'(req_ready), 64'd0);
        tick();
        rst = 1'b0;
        resp_ready = 1'b1;
        #1;
        chk("rst_release_ready", 64'(req_ready), 64'd1);
        for (int k = 0; k < 6; k++) begin
            chk("no_stale_resp", 64'(resp_valid), 64'd0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
